// File: rtl/vram_pkg.sv
// Shared types for the screen RAM arbiter: access tags, attribute area base and address helper.
// The attribute fetch path is only built when VRAM_ATTR_EN is defined.
package vram_pkg;

    localparam logic [12:0] ATTR_BASE_DEF = 13'h1800;

    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_VBMP,
        TAG_VATTR,
        TAG_CPURD,
        TAG_CPUWR
    } tag_t;

    // Attribute cell for a bitmap byte: character row {y[7:6],y[5:3]} and column x[7:3].
    function automatic logic [12:0] attrAddr(input logic [12:0] base, input logic [12:0] bmpAddr);
        attrAddr = base + {3'b000, bmpAddr[12:11], bmpAddr[7:5], bmpAddr[4:0]};
    endfunction

endpackage

// File: rtl/vram_tag_pipe.sv
// Two-stage shift register carrying the access tag alongside the RAM read latency.
// Stage 1 matches the cycle the RAM sees the address, stage 2 the cycle read data is valid.
module vram_tag_pipe
    import vram_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  tag_t i_tag,
    output tag_t o_stage1,
    output tag_t o_stage2
);

    tag_t r_stage1;
    tag_t r_stage2;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_stage1 <= TAG_NONE;
            r_stage2 <= TAG_NONE;
        end else begin
            r_stage1 <= i_tag;
            r_stage2 <= r_stage1;
        end
    end

    assign o_stage1 = r_stage1;
    assign o_stage2 = r_stage2;

endmodule

// File: rtl/vram_arbiter.sv
// Screen RAM arbiter: video fetches take the slot at fixed latency, the CPU fills free slots.
// Define VRAM_ATTR_EN to add the attribute byte fetch and the sticky overrun flag.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
`ifdef VRAM_ATTR_EN
    ,
    parameter logic [ADDR_W-1:0] ATTR_BASE = ADDR_W'(ATTR_BASE_DEF)
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic [DATA_W-1:0] o_vid_data,
    output logic [DATA_W-1:0] o_vid_attr,
    output logic              o_vid_valid,
    output logic              o_vid_ovr,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    logic              w_vidIssue;
    logic              w_attrIssue;
    logic              w_cpuGrant;
    tag_t              w_issueTag;
    logic [ADDR_W-1:0] w_issueAddr;
    tag_t              w_tag1;
    tag_t              w_tag2;
    logic              r_cpuBusy;

`ifdef VRAM_ATTR_EN
    logic              r_attrPending;
    logic [ADDR_W-1:0] r_attrAddr;
    logic [DATA_W-1:0] r_bmpHold;

    assign w_attrIssue = r_attrPending;
    assign w_vidIssue  = i_vid_req && !r_attrPending;

    // A new request landing on the pending attribute slot is dropped and flagged.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_attrPending <= 1'b0;
            r_attrAddr    <= '0;
            o_vid_ovr     <= 1'b0;
        end else begin
            r_attrPending <= w_vidIssue;
            if (w_vidIssue) begin
                r_attrAddr <= ADDR_W'(attrAddr(13'(ATTR_BASE), 13'(i_vid_addr)));
            end
            if (i_vid_req && r_attrPending) begin
                o_vid_ovr <= 1'b1;
            end
        end
    end
`else
    assign w_attrIssue = 1'b0;
    assign w_vidIssue  = i_vid_req;
    assign o_vid_attr  = '0;
    assign o_vid_ovr   = 1'b0;
`endif

    assign w_cpuGrant = i_cpu_req && !r_cpuBusy && !w_vidIssue && !w_attrIssue;

    always_comb begin
        w_issueTag  = TAG_NONE;
        w_issueAddr = '0;
`ifdef VRAM_ATTR_EN
        if (w_attrIssue) begin
            w_issueTag  = TAG_VATTR;
            w_issueAddr = r_attrAddr;
        end else
`endif
        if (w_vidIssue) begin
            w_issueTag  = TAG_VBMP;
            w_issueAddr = i_vid_addr;
        end else if (w_cpuGrant) begin
            w_issueTag  = i_cpu_we ? TAG_CPUWR : TAG_CPURD;
            w_issueAddr = i_cpu_addr;
        end
    end

    // The CPU stays busy through its ack cycle so a held request is not re-sampled there.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
            r_cpuBusy   <= 1'b0;
        end else begin
            o_ram_we <= 1'b0;
            if (w_issueTag != TAG_NONE) begin
                o_ram_addr <= w_issueAddr;
            end
            if (w_cpuGrant) begin
                o_ram_we    <= i_cpu_we;
                o_ram_wdata <= i_cpu_wdata;
                r_cpuBusy   <= 1'b1;
            end else if (o_cpu_ack) begin
                r_cpuBusy <= 1'b0;
            end
        end
    end

    vram_tag_pipe u_tagPipe (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_tag    (w_issueTag),
        .o_stage1 (w_tag1),
        .o_stage2 (w_tag2)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_vid_data  <= '0;
            o_vid_valid <= 1'b0;
            o_cpu_rdata <= '0;
            o_cpu_ack   <= 1'b0;
`ifdef VRAM_ATTR_EN
            o_vid_attr  <= '0;
            r_bmpHold   <= '0;
`endif
        end else begin
            o_vid_valid <= 1'b0;
            o_cpu_ack   <= (w_tag1 == TAG_CPUWR);
            case (w_tag2)
                TAG_CPURD: begin
                    o_cpu_rdata <= i_ram_rdata;
                    o_cpu_ack   <= 1'b1;
                end
`ifdef VRAM_ATTR_EN
                TAG_VBMP: r_bmpHold <= i_ram_rdata;
                TAG_VATTR: begin
                    o_vid_data  <= r_bmpHold;
                    o_vid_attr  <= i_ram_rdata;
                    o_vid_valid <= 1'b1;
                end
`else
                TAG_VBMP: begin
                    o_vid_data  <= i_ram_rdata;
                    o_vid_valid <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 8 KB screen RAM.
// Covers both builds; VRAM_ATTR_EN selects the attribute-fetch expectations.
module tb_vram_arbiter;

`ifdef VRAM_ATTR_EN
    localparam int         LAT      = 3;
    localparam logic [7:0] ATTR123  = 8'h11;
`else
    localparam int         LAT      = 2;
    localparam logic [7:0] ATTR123  = 8'h00;
`endif

    logic        clk;
    logic        reset;
    logic        vidReq;
    logic [12:0] vidAddr;
    logic [7:0]  vidData;
    logic [7:0]  vidAttr;
    logic        vidValid;
    logic        vidOvr;
    logic        cpuReq;
    logic        cpuWe;
    logic [12:0] cpuAddr;
    logic [7:0]  cpuWdata;
    logic [7:0]  cpuRdata;
    logic        cpuAck;
    logic [12:0] ramAddr;
    logic        ramWe;
    logic [7:0]  ramWdata;
    logic [7:0]  ramRdata;

    logic [7:0]  mem [0:8191];
    int          checks;
    int          errors;

    vram_arbiter dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_vid_req   (vidReq),
        .i_vid_addr  (vidAddr),
        .o_vid_data  (vidData),
        .o_vid_attr  (vidAttr),
        .o_vid_valid (vidValid),
        .o_vid_ovr   (vidOvr),
        .i_cpu_req   (cpuReq),
        .i_cpu_we    (cpuWe),
        .i_cpu_addr  (cpuAddr),
        .i_cpu_wdata (cpuWdata),
        .o_cpu_rdata (cpuRdata),
        .o_cpu_ack   (cpuAck),
        .o_ram_addr  (ramAddr),
        .o_ram_we    (ramWe),
        .o_ram_wdata (ramWdata),
        .i_ram_rdata (ramRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramWe) mem[ramAddr] <= ramWdata;
        ramRdata <= mem[ramAddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vr, input logic [12:0] va, input logic cr,
                                 input logic cwe, input logic [12:0] ca, input logic [7:0] cwd);
        vidReq   = vr;
        vidAddr  = va;
        cpuReq   = cr;
        cpuWe    = cwe;
        cpuAddr  = ca;
        cpuWdata = cwd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        ramRdata = 8'h00;
        applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
        for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
        mem[13'h0123] = 8'hA5;
        mem[13'h1823] = 8'h11;
        mem[13'h0010] = 8'h3C;
        mem[13'h0821] = 8'h5A;
        mem[13'h1921] = 8'h77;

        // Reset held with requests toggling: nothing may issue or complete.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i[0], 13'h0123, ~i[0], 1'b1, 13'h0010, 8'hFF);
            tick();
            checkOutput("rst_valid", 32'(vidValid), 32'd0);
            checkOutput("rst_ack", 32'(cpuAck), 32'd0);
            checkOutput("rst_we", 32'(ramWe), 32'd0);
            checkOutput("rst_addr", 32'(ramAddr), 32'd0);
            checkOutput("rst_ovr", 32'(vidOvr), 32'd0);
        end
        applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
        reset = 1'b1;
        tick();
        checkOutput("rel_data", 32'(vidData), 32'd0);
        checkOutput("rel_rdata", 32'(cpuRdata), 32'd0);
        checkOutput("rel_wdata", 32'(ramWdata), 32'd0);
        checkOutput("mem_untouched", 32'(mem[13'h0010]), 32'h3C);

        // Lone video fetch.
        applyStimulus(1'b1, 13'h0123, 1'b0, 1'b0, 13'h0, 8'h0);
        tick();
        applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
        checkOutput("v_addr", 32'(ramAddr), 32'h0123);
        checkOutput("v_we", 32'(ramWe), 32'd0);
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
`ifdef VRAM_ATTR_EN
            if (k == 1) checkOutput("v_attr_addr", 32'(ramAddr), 32'h1823);
`endif
            checkOutput("v_valid", 32'(vidValid), 32'(k == LAT));
            if (k == LAT) begin
                checkOutput("v_data", 32'(vidData), 32'hA5);
                checkOutput("v_attr", 32'(vidAttr), 32'(ATTR123));
            end
        end

        // CPU write then read-back of the same location.
        applyStimulus(1'b0, 13'h0, 1'b1, 1'b1, 13'h1800, 8'h47);
        tick();
        checkOutput("w_we", 32'(ramWe), 32'd1);
        checkOutput("w_addr", 32'(ramAddr), 32'h1800);
        checkOutput("w_wdata", 32'(ramWdata), 32'h47);
        checkOutput("w_ack_early", 32'(cpuAck), 32'd0);
        tick();
        checkOutput("w_ack", 32'(cpuAck), 32'd1);
        checkOutput("w_we_drop", 32'(ramWe), 32'd0);
        applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
        tick();
        checkOutput("w_ack_pulse", 32'(cpuAck), 32'd0);
        applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 13'h1800, 8'h00);
        tick();
        checkOutput("r_addr", 32'(ramAddr), 32'h1800);
        checkOutput("r_we", 32'(ramWe), 32'd0);
        tick();
        checkOutput("r_ack_early", 32'(cpuAck), 32'd0);
        tick();
        checkOutput("r_ack", 32'(cpuAck), 32'd1);
        checkOutput("r_rdata", 32'(cpuRdata), 32'h47);
        applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
        tick();
        checkOutput("r_ack_pulse", 32'(cpuAck), 32'd0);

        // Simultaneous video and CPU read: video first, CPU takes the next free slot.
        applyStimulus(1'b1, 13'h0123, 1'b1, 1'b0, 13'h0010, 8'h00);
        tick();
        applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 13'h0010, 8'h00);
        checkOutput("c_vid_first", 32'(ramAddr), 32'h0123);
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (k == LAT - 1) checkOutput("c_cpu_addr", 32'(ramAddr), 32'h0010);
            checkOutput("c_valid", 32'(vidValid), 32'(k == LAT));
            checkOutput("c_ack", 32'(cpuAck), 32'(k == LAT + 1));
            if (k == LAT) checkOutput("c_vdata", 32'(vidData), 32'hA5);
            if (k == LAT + 1) begin
                checkOutput("c_rdata", 32'(cpuRdata), 32'h3C);
                applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
            end
        end

        // Attribute address mapping for a second screen third.
        applyStimulus(1'b1, 13'h0821, 1'b0, 1'b0, 13'h0, 8'h0);
        tick();
        applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
        checkOutput("m_addr", 32'(ramAddr), 32'h0821);
        for (int k = 1; k <= LAT; k++) begin
            tick();
`ifdef VRAM_ATTR_EN
            if (k == 1) checkOutput("m_attr_addr", 32'(ramAddr), 32'h1921);
`endif
            checkOutput("m_valid", 32'(vidValid), 32'(k == LAT));
        end
        checkOutput("m_data", 32'(vidData), 32'h5A);
`ifdef VRAM_ATTR_EN
        checkOutput("m_attr", 32'(vidAttr), 32'h77);
`else
        checkOutput("m_attr", 32'(vidAttr), 32'h00);
`endif
        checkOutput("m_ovr", 32'(vidOvr), 32'd0);
        tick();

        // Back-to-back video requests.
        applyStimulus(1'b1, 13'h0123, 1'b0, 1'b0, 13'h0, 8'h0);
        tick();
        applyStimulus(1'b1, 13'h0821, 1'b0, 1'b0, 13'h0, 8'h0);
        tick();
        applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
`ifdef VRAM_ATTR_EN
        checkOutput("b_ovr_set", 32'(vidOvr), 32'd1);
        checkOutput("b_attr_slot", 32'(ramAddr), 32'h1823);
        tick();
        checkOutput("b_dropped", 32'(ramAddr), 32'h1823);
        tick();
        checkOutput("b_valid1", 32'(vidValid), 32'd1);
        checkOutput("b_data1", 32'(vidData), 32'hA5);
        checkOutput("b_attr1", 32'(vidAttr), 32'h11);
        tick();
        checkOutput("b_no_second", 32'(vidValid), 32'd0);
        tick();
        checkOutput("b_no_second2", 32'(vidValid), 32'd0);
        checkOutput("b_ovr_sticky", 32'(vidOvr), 32'd1);
`else
        checkOutput("b_addr2", 32'(ramAddr), 32'h0821);
        checkOutput("b_ovr", 32'(vidOvr), 32'd0);
        tick();
        checkOutput("b_valid1", 32'(vidValid), 32'd1);
        checkOutput("b_data1", 32'(vidData), 32'hA5);
        tick();
        checkOutput("b_valid2", 32'(vidValid), 32'd1);
        checkOutput("b_data2", 32'(vidData), 32'h5A);
        checkOutput("b_attr2", 32'(vidAttr), 32'h00);
        tick();
        checkOutput("b_valid_end", 32'(vidValid), 32'd0);
`endif

        // Reset is the only thing that clears the overrun flag.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("f_ovr_clr", 32'(vidOvr), 32'd0);
        checkOutput("f_data_clr", 32'(vidData), 32'd0);
        checkOutput("f_addr_clr", 32'(ramAddr), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
